// File: rtl/hsi_pkg.sv
// Shared definitions for the HSI slave receive path.
// Contents: CRC16-CCITT constants and byte update function, receive frame
// state encoding, and the flag byte values that open HSI frames.
package hsi_pkg;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam logic [7:0] FLAG_CONTROL_COMMAND_WORD = 8'h11;
  localparam logic [7:0] FLAG_DATA_PACKET_REQUEST  = 8'h22;
  localparam logic [7:0] FLAG_STATUS_REQUEST       = 8'h33;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2
  } rx_state_t;

  // One full byte of CCITT (MSB-first, no reflection); unrolls to a single
  // combinational stage.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c,
                                             input logic [7:0]  d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/hsi_rx_crc16.sv
// Byte-parallel CRC16-CCITT register for the receive frame controller.
// Ports:
//   clk, rst   clock and synchronous active-high reset (register -> 0xFFFF)
//   init       restart the register at 0xFFFF
//   en         fold byte d into the register; with init, folds d into 0xFFFF
//   d[7:0]     byte to fold in
//   crc[15:0]  current register value (0x0000 after a good frame + CRC)
module hsi_rx_crc16
  import hsi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_byte(init ? CRC_INIT : crc, d);
    end else if (init) begin
      crc <= CRC_INIT;
    end
  end

endmodule

// File: rtl/hsi_s_rx_frame_ctrl.sv
// HSI slave receive frame controller.
// Delimits frames by line-idle gaps, captures the leading flag byte, strips
// the trailing two CRC bytes through a 2-deep delay line and forwards the
// payload. Closes each frame with rx_frame_end (good) or rx_err (rejected).
// Build option: HSI_RX_CRC_CHECK_EN -- when defined, the CRC residue is
// checked; otherwise only length and decoder errors reject a frame.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clk_en        line-rate tick for the gap counter
//   dec_d         decoded byte, valid with dec_d_rdy strobe
//   dec_err       decoder code violation strobe
//   rx_flag       flag byte of current/last frame
//   rx_d/rx_d_rdy payload byte and its strobe (not yet CRC-verified)
//   rx_len        payload count of current/last frame
//   rx_frame_end  pulse: frame closed with good CRC
//   rx_err        pulse: frame rejected
//   rx_busy       high while not idle
module hsi_s_rx_frame_ctrl
  import hsi_pkg::*;
#(
  parameter int unsigned GAP_TICKS = 16,
  parameter int unsigned MAX_LEN   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] dec_d,
  input  logic       dec_d_rdy,
  input  logic       dec_err,
  output logic [7:0] rx_flag,
  output logic [7:0] rx_d,
  output logic       rx_d_rdy,
  output logic [7:0] rx_len,
  output logic       rx_frame_end,
  output logic       rx_err,
  output logic       rx_busy
);

  localparam int unsigned GW = $clog2(GAP_TICKS + 1);

  rx_state_t      state, state_nx;
  logic [GW-1:0]  gap_cnt;
  logic           gap_hit;
  logic [7:0]     dl0, dl1;     // dl0 is the oldest byte
  logic [1:0]     dl_cnt;
  logic           crc_ok;

  logic flag_ld, fwd, push, flush, end_nx, err_nx;

`ifdef HSI_RX_CRC_CHECK_EN
  logic [15:0] crc;

  hsi_rx_crc16 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (flag_ld),
    .en   (flag_ld | push),
    .d    (dec_d),
    .crc  (crc)
  );

  assign crc_ok = (crc == 16'h0000);
`else
  assign crc_ok = 1'b1;
`endif

  // A byte or error in the threshold cycle takes priority over closing.
  assign gap_hit = (gap_cnt == GW'(GAP_TICKS)) && !dec_d_rdy && !dec_err;
  assign rx_busy = (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    flag_ld  = 1'b0;
    fwd      = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
    end_nx   = 1'b0;
    err_nx   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dec_err) begin
          state_nx = ST_DROP;
        end else if (dec_d_rdy) begin
          flag_ld  = 1'b1;
          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (dec_err) begin
          err_nx   = 1'b1;
          flush    = 1'b1;
          state_nx = ST_DROP;
        end else if (dec_d_rdy) begin
          if (dl_cnt == 2'd2 && rx_len == 8'(MAX_LEN)) begin
            err_nx   = 1'b1;
            flush    = 1'b1;
            state_nx = ST_DROP;
          end else begin
            push = 1'b1;
            fwd  = (dl_cnt == 2'd2);
          end
        end else if (gap_hit) begin
          flush    = 1'b1;
          state_nx = ST_IDLE;
          if (dl_cnt != 2'd2 || !crc_ok) begin
            err_nx = 1'b1;
          end else begin
            end_nx = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (gap_hit) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      gap_cnt      <= '0;
      dl0          <= '0;
      dl1          <= '0;
      dl_cnt       <= '0;
      rx_flag      <= '0;
      rx_d         <= '0;
      rx_d_rdy     <= 1'b0;
      rx_len       <= '0;
      rx_frame_end <= 1'b0;
      rx_err       <= 1'b0;
    end else begin
      state        <= state_nx;
      rx_d_rdy     <= fwd;
      rx_frame_end <= end_nx;
      rx_err       <= err_nx;

      if (dec_d_rdy || dec_err) begin
        gap_cnt <= '0;
      end else if (clk_en && gap_cnt != GW'(GAP_TICKS)) begin
        gap_cnt <= gap_cnt + GW'(1);
      end

      if (fwd) begin
        rx_d <= dl0;
      end

      if (flag_ld) begin
        rx_flag <= dec_d;
        rx_len  <= '0;
      end else if (fwd) begin
        rx_len <= rx_len + 8'd1;
      end

      if (flush) begin
        dl_cnt <= '0;
      end else if (push) begin
        case (dl_cnt)
          2'd0: begin
            dl0    <= dec_d;
            dl_cnt <= 2'd1;
          end
          2'd1: begin
            dl1    <= dec_d;
            dl_cnt <= 2'd2;
          end
          default: begin
            dl0 <= dl1;
            dl1 <= dec_d;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hsi_s_rx_frame_ctrl.sv
module tb_hsi_s_rx_frame_ctrl;
  import hsi_pkg::*;

  localparam int GAP = 16;
  localparam int MAXL [2] = '{32, 4};
`ifdef HSI_RX_CRC_CHECK_EN
  localparam bit CRC_CHK = 1'b1;
`else
  localparam bit CRC_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, clk_en, dec_d_rdy, dec_err;
  logic [7:0] dec_d;
  logic [7:0] rxflag [2];
  logic [7:0] rxd    [2];
  logic [7:0] rxlen  [2];
  logic       rxrdy  [2];
  logic       rxend  [2];
  logic       rxerr  [2];
  logic       rxbusy [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hsi_s_rx_frame_ctrl #(.GAP_TICKS(GAP), .MAX_LEN(32)) dut_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .dec_d(dec_d),
    .dec_d_rdy(dec_d_rdy), .dec_err(dec_err),
    .rx_flag(rxflag[0]), .rx_d(rxd[0]), .rx_d_rdy(rxrdy[0]),
    .rx_len(rxlen[0]), .rx_frame_end(rxend[0]), .rx_err(rxerr[0]),
    .rx_busy(rxbusy[0])
  );

  hsi_s_rx_frame_ctrl #(.GAP_TICKS(GAP), .MAX_LEN(4)) dut_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .dec_d(dec_d),
    .dec_d_rdy(dec_d_rdy), .dec_err(dec_err),
    .rx_flag(rxflag[1]), .rx_d(rxd[1]), .rx_d_rdy(rxrdy[1]),
    .rx_len(rxlen[1]), .rx_frame_end(rxend[1]), .rx_err(rxerr[1]),
    .rx_busy(rxbusy[1])
  );

  // Observation record, sampled 1 ns after each rising edge.
  logic [7:0] pay [2][64];
  int npay [2];
  int n_end [2];
  int n_err [2];
  int n_both [2];

  always @(posedge clk) begin
    #1;
    for (int j = 0; j < 2; j++) begin
      if (rxrdy[j]) begin
        if (npay[j] < 64) pay[j][npay[j]] = rxd[j];
        npay[j]++;
      end
      if (rxend[j]) n_end[j]++;
      if (rxerr[j]) n_err[j]++;
      if (rxend[j] && rxerr[j]) n_both[j]++;
    end
  end

  logic [7:0] frame [$];

  // Reference CRC: bit-serial long division over frame[0..n-1].
  function automatic logic [15:0] ref_crc(int n);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ frame[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    return c;
  endfunction

  task automatic clear_mon();
    for (int j = 0; j < 2; j++) begin
      npay[j] = 0; n_end[j] = 0; n_err[j] = 0; n_both[j] = 0;
    end
  endtask

  // Called at a falling edge; presents one byte for one cycle.
  task automatic drive_byte(input logic [7:0] b, input logic e);
    dec_d = b; dec_d_rdy = 1'b1; dec_err = e;
    @(negedge clk);
    dec_d_rdy = 1'b0; dec_err = 1'b0;
  endtask

  task automatic idle_gap();
    clk_en = 1'b1;
    repeat (GAP + 4) @(negedge clk);
    clk_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Drives 'frame' (dec_err on err_idx, exact-threshold stall before
  // stall_idx) and checks both instances against the frame-level model.
  task automatic run_frame(input int err_idx, input int stall_idx);
    int sp, k, att, fwd, m;
    bit e_end, e_err, ex;
    clear_mon();
    for (int i = 0; i < frame.size(); i++) begin
      if (i > 0) begin
        if (i == stall_idx) begin
          clk_en = 1'b1;
          repeat (GAP) @(negedge clk);
          clk_en = 1'b0;
        end else begin
          sp = $urandom_range(0, 3);
          repeat (sp) begin
            clk_en = 1'($urandom % 2);
            @(negedge clk);
          end
          clk_en = 1'b0;
        end
      end
      drive_byte(frame[i], i == err_idx);
      if (i == err_idx) begin
        for (int j = 0; j < 2; j++) begin
          att = (i > 3) ? i - 3 : 0;
          ex = (att <= MAXL[j]);
          checks++;
          if (rxerr[j] !== ex) begin
            errors++;
            $display("FAIL err_latency inst%0d: rx_err=%0b expected %0b", j, rxerr[j], ex);
          end
        end
      end
    end
    idle_gap();
    for (int j = 0; j < 2; j++) begin
      m = MAXL[j];
      k = (err_idx >= 1) ? err_idx - 1 : frame.size() - 1;
      att = (k > 2) ? k - 2 : 0;
      e_end = 1'b0; e_err = 1'b0;
      if (att > m) begin
        fwd = m; e_err = 1'b1;
      end else begin
        fwd = att;
        if (err_idx >= 1 || k < 2 || (CRC_CHK && ref_crc(frame.size()) != 16'h0000))
          e_err = 1'b1;
        else
          e_end = 1'b1;
      end
      checks++;
      if (npay[j] !== fwd) begin
        errors++;
        $display("FAIL payload_count inst%0d: got %0d expected %0d", j, npay[j], fwd);
      end
      for (int p = 0; p < fwd && p < npay[j]; p++) begin
        checks++;
        if (pay[j][p] !== frame[p+1]) begin
          errors++;
          $display("FAIL payload_byte inst%0d[%0d]: got %02h expected %02h", j, p, pay[j][p], frame[p+1]);
        end
      end
      checks++;
      if (n_end[j] !== int'(e_end) || n_err[j] !== int'(e_err)) begin
        errors++;
        $display("FAIL close_pulse inst%0d: end=%0d err=%0d expected end=%0d err=%0d",
                 j, n_end[j], n_err[j], e_end, e_err);
      end
      checks++;
      if (n_both[j] !== 0) begin
        errors++;
        $display("FAIL pulse_overlap inst%0d: %0d cycles with both high", j, n_both[j]);
      end
      checks++;
      if (rxflag[j] !== frame[0] || rxlen[j] !== 8'(fwd)) begin
        errors++;
        $display("FAIL held_flag_len inst%0d: flag=%02h len=%0d expected flag=%02h len=%0d",
                 j, rxflag[j], rxlen[j], frame[0], fwd);
      end
      checks++;
      if (rxbusy[j] !== 1'b0) begin
        errors++;
        $display("FAIL busy_after inst%0d: got %0b expected 0", j, rxbusy[j]);
      end
    end
  endtask

  task automatic load_123456789(input logic [7:0] last);
    frame.delete();
    for (int i = 0; i < 9; i++) frame.push_back(8'h31 + 8'(i));
    frame.push_back(8'h29);
    frame.push_back(last);
  endtask

  task automatic test_reset();
    for (int j = 0; j < 2; j++) begin
      checks++;
      if ({rxflag[j], rxd[j], rxrdy[j], rxlen[j], rxend[j], rxerr[j], rxbusy[j]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: flag=%02h d=%02h rdy=%0b len=%0d end=%0b err=%0b busy=%0b expected all 0",
                 j, rxflag[j], rxd[j], rxrdy[j], rxlen[j], rxend[j], rxerr[j], rxbusy[j]);
      end
    end
  endtask

  // Back-to-back bytes with exact strobe and close latency on instance A.
  task automatic test_good_frame();
    int n;
    load_123456789(8'hB1);
    for (int i = 0; i < frame.size(); i++) begin
      drive_byte(frame[i], 1'b0);
      checks++;
      if (rxrdy[0] !== (i >= 3) || (i >= 3 && rxd[0] !== frame[i-2])) begin
        errors++;
        $display("FAIL strobe_latency byte%0d: rdy=%0b d=%02h expected rdy=%0b d=%02h",
                 i, rxrdy[0], rxd[0], (i >= 3), (i >= 3) ? frame[i-2] : 8'h00);
      end
    end
    clk_en = 1'b1;
    n = 0;
    while (n < 40 && !rxend[0] && !rxerr[0]) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rxend[0] !== 1'b1 || n !== GAP + 1) begin
      errors++;
      $display("FAIL good_close: end=%0b err=%0b after %0d cycles expected end=1 after %0d",
               rxend[0], rxerr[0], n, GAP + 1);
    end
    checks++;
    if (rxflag[0] !== 8'h31 || rxlen[0] !== 8'd8) begin
      errors++;
      $display("FAIL good_flag_len: flag=%02h len=%0d expected 31 8", rxflag[0], rxlen[0]);
    end
    idle_gap();
    // Same frame again through the randomised-spacing path.
    run_frame(-1, -1);
  endtask

  task automatic test_corrupt_crc();
    load_123456789(8'hB0);
    run_frame(-1, -1);
  endtask

  task automatic test_dec_err();
    load_123456789(8'hB1);
    run_frame(3, -1);
    load_123456789(8'hB1);
    run_frame(-1, -1);
  endtask

  task automatic test_short();
    frame.delete();
    frame.push_back(FLAG_CONTROL_COMMAND_WORD);
    frame.push_back(8'($urandom));
    run_frame(-1, -1);
    frame.delete();
    frame.push_back(FLAG_STATUS_REQUEST);
    run_frame(-1, -1);
  endtask

  task automatic test_overflow();
    logic [15:0] c;
    frame.delete();
    frame.push_back(FLAG_DATA_PACKET_REQUEST);
    for (int i = 0; i < 7; i++) frame.push_back(8'($urandom));
    c = ref_crc(frame.size());
    frame.push_back(c[15:8]);
    frame.push_back(c[7:0]);
    run_frame(-1, -1);
  endtask

  task automatic test_reset_mid();
    clear_mon();
    drive_byte(8'h22, 1'b0);
    for (int i = 0; i < 4; i++) drive_byte(8'h40 + 8'(i), 1'b0);
    checks++;
    if (rxbusy[0] !== 1'b1 || rxlen[0] !== 8'd2) begin
      errors++;
      $display("FAIL mid_frame_state: busy=%0b len=%0d expected 1 2", rxbusy[0], rxlen[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      checks++;
      if ({rxflag[j], rxd[j], rxrdy[j], rxlen[j], rxend[j], rxerr[j], rxbusy[j]} !== '0) begin
        errors++;
        $display("FAIL reset_mid_outputs inst%0d: flag=%02h d=%02h len=%0d busy=%0b expected all 0",
                 j, rxflag[j], rxd[j], rxlen[j], rxbusy[j]);
      end
    end
    idle_gap();
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (n_end[j] !== 0 || n_err[j] !== 0) begin
        errors++;
        $display("FAIL reset_mid_pulse inst%0d: end=%0d err=%0d expected 0 0", j, n_end[j], n_err[j]);
      end
    end
    load_123456789(8'hB1);
    run_frame(-1, -1);
  endtask

  task automatic test_gap_coincident();
    load_123456789(8'hB1);
    run_frame(-1, 5);
    load_123456789(8'hB1);
    run_frame(-1, 1);
  endtask

  task automatic test_random();
    logic [15:0] c;
    int plen, idx, e_idx, s_idx, fsel;
    for (int t = 0; t < 30; t++) begin
      frame.delete();
      fsel = $urandom_range(0, 3);
      case (fsel)
        0: frame.push_back(FLAG_CONTROL_COMMAND_WORD);
        1: frame.push_back(FLAG_DATA_PACKET_REQUEST);
        2: frame.push_back(FLAG_STATUS_REQUEST);
        default: frame.push_back(8'($urandom));
      endcase
      plen = $urandom_range(0, 9);
      for (int i = 0; i < plen; i++) frame.push_back(8'($urandom));
      c = ref_crc(frame.size());
      frame.push_back(c[15:8]);
      frame.push_back(c[7:0]);
      if ($urandom % 4 == 0) begin
        idx = $urandom_range(0, frame.size() - 1);
        frame[idx] = frame[idx] ^ (8'h01 << $urandom_range(0, 7));
      end
      e_idx = ($urandom % 5 == 0) ? $urandom_range(1, frame.size() - 1) : -1;
      s_idx = ($urandom % 4 == 0) ? $urandom_range(1, frame.size() - 1) : -1;
      run_frame(e_idx, s_idx);
    end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; dec_d = 8'h00; dec_d_rdy = 1'b0; dec_err = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_corrupt_crc();
    test_dec_err();
    test_short();
    test_overflow();
    test_reset_mid();
    test_gap_coincident();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
